// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, HALT encoding, fetch FSM states and
// the prefetch entry layout.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
// clear has priority over push; pop on empty and push on full are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;
    logic [DEPTH-1:0] wr_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = do_push && (wr_ptr_q == AW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= din_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, 1-cycle ROM interface, credit-gated prefetch FIFO and
// redirect flush. Define FETCH_HALT_EN to stop fetching on the HALT encoding.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, inflight_pc_q;
    logic              inflight_q;

    logic              issue, push, pop, clear, has_credit;
    logic [CW-1:0]     fifo_count, occ;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_dout;

    assign pop = out_valid && out_ready;
    // Occupancy counts the in-flight ROM read so its push can never overflow.
    assign occ = fifo_count + CW'(inflight_q) - CW'(pop);
    assign has_credit = (occ < CW'(FIFO_DEPTH)) && !(fifo_full && !pop);
    assign push = inflight_q && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            RUN, FLUSH: begin
                if (redirect_valid) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end else begin
                    state_d = RUN;
                    issue   = has_credit;
`ifdef FETCH_HALT_EN
                    if (push && (imem_instr == DATA_W'(HALT_INSTR))) begin
                        state_d = HALT;
                    end
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                if (redirect_valid) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (clear) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + ADDR_W'(1);
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .srst_i  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .din_i   ({inflight_pc_q, imem_instr}),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_empty ? '0 : fifo_dout[EW-1:DATA_W];
    assign out_instr = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a ROM model answers with one cycle of
// latency, expected PCs are queued at stimulus time and popped on each beat.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;
    int b0;
    logic        halt_rom = 1'b0;
    logic [7:0]  exp_q [$];
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_pc;
    logic [31:0] prev_instr;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (halt_rom && a == 8'd3) return 32'hFFFF_FFFF;
        return 32'h100 + {24'b0, a};
    endfunction

    always @(posedge clk) imem_instr <= rom_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic load_seq(input logic [7:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat checker and hold-stability checker, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            if (prev_hold) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_pc", 32'(out_pc), 32'(prev_pc));
                check_eq("hold_instr", out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                beats++;
                $display("beat pc=%h instr=%h", out_pc, out_instr);
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_pc", 32'(out_pc), 32'(e));
                    check_eq("beat_instr", out_instr, rom_word(e));
                end
            end
        end
        prev_hold  = !rst_n && !redirect_valid && out_valid && !out_ready;
        prev_pc    = out_pc;
        prev_instr = out_instr;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc", 32'(out_pc), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);

        // Release with decode always ready: first beat two cycles after issue.
        tick(); rst_n = 1'b0; out_ready = 1'b1; load_seq(8'h00, 100);
        @(negedge clk); check_eq("lat_c0_valid", 32'(out_valid), 32'd0);
        tick(); @(negedge clk); check_eq("lat_c1_valid", 32'(out_valid), 32'd0);
        tick(); @(negedge clk);
        check_eq("lat_c2_valid", 32'(out_valid), 32'd1);
        check_eq("lat_c2_pc", 32'(out_pc), 32'd0);
        check_eq("lat_c2_instr", out_instr, 32'h100);
        b0 = beats;
        repeat (10) tick();
        @(negedge clk); check_eq("stream_beats", 32'(beats - b0), 32'd10);

        // Stall from reset: FIFO fills, PC parks at 4.
        tick(); rst_n = 1'b1; out_ready = 1'b0;
        tick(); rst_n = 1'b0; load_seq(8'h00, 100);
        repeat (10) tick();
        @(negedge clk);
        check_eq("stall_addr", 32'(imem_addr), 32'd4);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_head", 32'(out_pc), 32'd0);
        b0 = beats; out_ready = 1'b1;
        repeat (14) tick();
        @(negedge clk); check_eq("stall_release_beats", 32'(beats - b0 >= 10), 32'd1);

        // Leave pc 2..5 buffered, then redirect to 0x40 under stall.
        tick(); rst_n = 1'b1; out_ready = 1'b0;
        tick(); rst_n = 1'b0; load_seq(8'h00, 100);
        repeat (8) tick();
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("pre_redir_head", 32'(out_pc), 32'd2);
        check_eq("pre_redir_addr", 32'(imem_addr), 32'd6);
        tick(); redirect_valid = 1'b1; redirect_pc = 8'h40; load_seq(8'h40, 40);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); check_eq("redir_r1_valid", 32'(out_valid), 32'd0);
        tick(); @(negedge clk); check_eq("redir_r2_valid", 32'(out_valid), 32'd0);
        tick(); @(negedge clk);
        check_eq("redir_r3_valid", 32'(out_valid), 32'd1);
        check_eq("redir_r3_pc", 32'(out_pc), 32'h40);
        repeat (6) tick();

        // Back-to-back redirects; the later target 0xFE wins and wraps.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h80;
        tick(); redirect_pc = 8'hFE; load_seq(8'hFE, 40);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        b0 = beats;
        tick(); tick();
        @(negedge clk);
        check_eq("wrap_valid", 32'(out_valid), 32'd1);
        check_eq("wrap_pc", 32'(out_pc), 32'hFE);
        repeat (6) tick();
        @(negedge clk); check_eq("wrap_beats", 32'(beats - b0 >= 4), 32'd1);

        // Reset mid-stream with a non-empty FIFO.
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk); check_eq("mid_nonempty", 32'(out_valid), 32'd1);
        tick(); rst_n = 1'b1;
        tick(); rst_n = 1'b0; out_ready = 1'b1; load_seq(8'h00, 100);
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_addr", 32'(imem_addr), 32'd0);
        b0 = beats;
        repeat (10) tick();
        @(negedge clk); check_eq("mid_rst_beats", 32'(beats - b0), 32'd8);

`ifdef FETCH_HALT_EN
        // HALT word at pc 3: pcs 0..3 drain, fetch parks after the pc 4 slot.
        tick(); rst_n = 1'b1; out_ready = 1'b0; halt_rom = 1'b1;
        tick(); rst_n = 1'b0; out_ready = 1'b1; load_seq(8'h00, 4);
        repeat (12) tick();
        @(negedge clk);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_addr", 32'(imem_addr), 32'd5);
        check_eq("halt_valid", 32'(out_valid), 32'd0);
        check_eq("halt_qsize", 32'(exp_q.size()), 32'd0);
        tick(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h00; load_seq(8'h00, 4);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); check_eq("resume_halted", 32'(halted), 32'd0);
        tick(); tick(); @(negedge clk);
        check_eq("resume_valid", 32'(out_valid), 32'd1);
        check_eq("resume_pc", 32'(out_pc), 32'd0);
        repeat (10) tick();
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
